xadc_drp_arbiter: RTL and testbench
===================================

Name: xadc_drp_arbiter

Overview:
Owns the XADC DRP port and shares it between two requesters. The first is the automatic sample readout, triggered on every end-of-conversion. The second is a host (MMIO) channel for reading or writing arbitrary XADC configuration/status registers, such as sequencer channel-enable, averaging and alarm thresholds. The block sits between the XADC primitive wrapper and the XADC MMIO core; the core keeps the per-channel sample registers and drives the host request interface.

Parameters:
TIMEOUT_CYCLES, 64, max cycles waiting for drdy after den before abort (≥4)
OVR_W, 8, width of saturating sample-overrun counter

Ports:
clk  in  1  system clock (also XADC dclk)
reset  in  1  asynchronous, active-high
eoc  in  1  XADC end-of-conversion pulse
channel  in  5  XADC channel of the completed conversion
host_req  in  1  host DRP request, level; held until host_ack
host_we  in  1  1=write, 0=read; stable while host_req
host_addr  in  7  DRP register address
host_wdata  in  16  write data
host_ack  out  1  one-cycle completion pulse
host_err  out  1  valid with host_ack; 1=timeout
host_rdata  out  16  read data, valid with host_ack, held until next ack
den  out  1  DRP enable, one-cycle pulse
dwe  out  1  DRP write enable, coincident with den
daddr  out  7  DRP address, held from den until completion
di  out  16  DRP write data
drdy  in  1  DRP data ready
do_data  in  16  DRP read data
smp_valid  out  1  one-cycle pulse: new sample
smp_chan  out  5  channel of sample, held
smp_data  out  16  sample value, held
ovr_cnt  out  OVR_W  saturating count of overwritten pending EOCs
busy  out  1  1 when FSM not IDLE

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All outputs are registered. Reset forces every output to 0 and the FSM to IDLE.
- EOC capture:
  - An eoc pulse sets eoc_pend and latches channel into chan_q, whatever the FSM state.
  - eoc while eoc_pend=1 (and not being consumed in the same cycle): chan_q is overwritten and ovr_cnt increments, saturating at all-ones.
  - eoc in the same cycle the pending request is granted: the new event re-sets eoc_pend with the new channel; no overrun is counted.
- FSM states: IDLE, SMP_WAIT, HOST_WAIT.
- IDLE, grant priority is fixed: eoc_pend first, then host_req.
  - eoc_pend=1: on the next edge, den=1, dwe=0, daddr={2'b00,chan_q}; clear eoc_pend; go to SMP_WAIT.
  - Else host_req=1: on the next edge, den=1, dwe=host_we, daddr=host_addr, di=host_wdata; go to HOST_WAIT.
  - The eoc pulse itself is not granted in the cycle it arrives. Earliest den is 2 cycles after eoc.
- SMP_WAIT / HOST_WAIT:
  - den is high for exactly one cycle. A timeout counter is cleared at den and increments each cycle.
  - drdy while in SMP_WAIT: next edge smp_valid=1, smp_data=do_data, smp_chan=daddr[4:0]; go to IDLE.
  - drdy while in HOST_WAIT: next edge host_ack=1, host_err=0, host_rdata=do_data (reads) or unchanged (writes); go to IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 with no drdy: go to IDLE. In HOST_WAIT, also pulse host_ack with host_err=1 and host_rdata=0. In SMP_WAIT, the sample is dropped with no smp_valid.
- drdy in IDLE is ignored.
- Minimum one IDLE cycle between transactions, so den never occurs in consecutive cycles.
- Host fairness: a host request waits at most for one sample transaction plus one pending EOC. The XADC conversion period is far greater than a DRP access, so the host cannot starve.
- host_req dropped before grant: nothing is issued. host_req is never sampled outside IDLE.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. Any stray drdy arriving after reset is ignored.

Decomposition:
- Package xadc_pkg holds:
  - state enum drp_state_t {IDLE, SMP_WAIT, HOST_WAIT}
  - DRP address constants (CH_TEMP=5'd0, CH_VCCINT=5'd1, CH_VAUX2=5'd18, CH_VAUX3=5'd19, CH_VAUX10=5'd26, CH_VAUX11=5'd27)
  - config register addresses (CFG0=7'h40, CFG1=7'h41, SEQ_CHSEL=7'h48/7'h49)
- No sub-module: the FSM, timeout counter and EOC latch live in one module.

Test Plan:
- Single EOC: eoc with channel=19, drdy 3 cycles after den with do_data=16'hA5A0 -> den at eoc+2 with daddr=7'h13, dwe=0; smp_valid one cycle after drdy; smp_chan=19; smp_data=16'hA5A0.
- Host write: host_req, we=1, addr=7'h41, wdata=16'h2000, no eoc -> den+dwe with daddr=7'h41, di=16'h2000; host_ack=1, host_err=0 one cycle after drdy; host_rdata unchanged.
- Collision: eoc (ch 0) and host read (7'h48) in the same cycle -> sample transaction first; host den issued after one IDLE cycle; both complete in that order.
- Overrun: eoc ch 26 during HOST_WAIT, then eoc ch 27 before grant -> ovr_cnt=1; the next sample transaction uses daddr=7'h1B.
- Timeout: host read and drdy withheld -> host_ack with host_err=1 and host_rdata=0 exactly TIMEOUT_CYCLES after den; FSM back in IDLE; a later sample transaction completes normally.
- Reset mid-HOST_WAIT: assert reset, then pulse drdy after release -> all outputs 0; no host_ack or smp_valid produced.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and XADC DRP address constants for the DRP arbiter and its users.
package xadc_pkg;

  // Arbiter FSM: idle, waiting on a sample readout, waiting on a host access
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SMP_WAIT  = 2'd1,
    HOST_WAIT = 2'd2
  } drp_state_t;

  // Status register addresses of commonly sampled channels
  localparam logic [4:0] CH_TEMP   = 5'd0;
  localparam logic [4:0] CH_VCCINT = 5'd1;
  localparam logic [4:0] CH_VAUX2  = 5'd18;
  localparam logic [4:0] CH_VAUX3  = 5'd19;
  localparam logic [4:0] CH_VAUX10 = 5'd26;
  localparam logic [4:0] CH_VAUX11 = 5'd27;

  // Configuration register addresses
  localparam logic [6:0] CFG0       = 7'h40;
  localparam logic [6:0] CFG1       = 7'h41;
  localparam logic [6:0] SEQ_CHSEL0 = 7'h48;
  localparam logic [6:0] SEQ_CHSEL1 = 7'h49;

endpackage

// File: rtl/xadc_drp_arbiter.sv
// Owns the XADC DRP port and shares it between EOC-triggered sample readout
// (fixed priority) and a host register read/write channel, with a drdy timeout.
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OVR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             eoc,
  input  logic [4:0]       channel,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [6:0]       host_addr,
  input  logic [15:0]      host_wdata,
  output logic             host_ack,
  output logic             host_err,
  output logic [15:0]      host_rdata,
  output logic             den,
  output logic             dwe,
  output logic [6:0]       daddr,
  output logic [15:0]      di,
  input  logic             drdy,
  input  logic [15:0]      do_data,
  output logic             smp_valid,
  output logic [4:0]       smp_chan,
  output logic [15:0]      smp_data,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  drp_state_t       state;
  drp_state_t       state_nx;
  logic             eoc_pend;
  logic [4:0]       chan_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             host_we_q;
  logic             grant_smp;
  logic             grant_host;
  logic             done_smp;
  logic             done_host;
  logic             tmo_host;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    if (&v) return v;
    return v + OVR_W'(1);
  endfunction

  // Next-state decode: grants in IDLE, completion or timeout in the wait states.
  // An EOC arriving this very cycle outranks the host even though it is only
  // granted on the following cycle, so a simultaneous host request waits.
  always_comb begin
    state_nx   = state;
    grant_smp  = 1'b0;
    grant_host = 1'b0;
    done_smp   = 1'b0;
    done_host  = 1'b0;
    tmo_host   = 1'b0;
    case (state)
      IDLE: begin
        if (eoc_pend) begin
          grant_smp = 1'b1;
          state_nx  = SMP_WAIT;
        end else if (host_req && !eoc) begin
          grant_host = 1'b1;
          state_nx   = HOST_WAIT;
        end
      end
      SMP_WAIT: begin
        if (drdy) begin
          done_smp = 1'b1;
          state_nx = IDLE;
        end else if (tmo_cnt == CNT_LAST) begin
          state_nx = IDLE;
        end
      end
      HOST_WAIT: begin
        if (drdy) begin
          done_host = 1'b1;
          state_nx  = IDLE;
        end else if (tmo_cnt == CNT_LAST) begin
          tmo_host = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control stage: FSM state, DRP/host/sample strobes and the timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      den       <= 1'b0;
      dwe       <= 1'b0;
      smp_valid <= 1'b0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
      host_we_q <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      den       <= grant_smp | grant_host;
      dwe       <= grant_host & host_we;
      smp_valid <= done_smp;
      host_ack  <= done_host | tmo_host;
      host_err  <= tmo_host;
      if (grant_host) host_we_q <= host_we;
      if (grant_smp || grant_host) tmo_cnt <= '0;
      else if (state != IDLE)      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // EOC latch: a new event always wins; overwriting an unconsumed one counts an overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoc_pend <= 1'b0;
      ovr_cnt  <= '0;
    end else if (eoc) begin
      eoc_pend <= 1'b1;
      if (eoc_pend && !grant_smp) ovr_cnt <= sat_inc(ovr_cnt);
    end else if (grant_smp) begin
      eoc_pend <= 1'b0;
    end
  end

  // Channel of the most recent EOC; only meaningful while eoc_pend is set
  always_ff @(posedge clk) begin
    if (eoc) chan_q <= channel;
  end

  // Data stage: DRP address/write data, captured sample and host read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      daddr      <= '0;
      di         <= '0;
      host_rdata <= '0;
      smp_chan   <= '0;
      smp_data   <= '0;
    end else begin
      if (grant_smp) begin
        daddr <= {2'b00, chan_q};
      end else if (grant_host) begin
        daddr <= host_addr;
        di    <= host_wdata;
      end
      if (done_smp) begin
        smp_chan <= daddr[4:0];
        smp_data <= do_data;
      end
      if (done_host && !host_we_q) host_rdata <= do_data;
      else if (tmo_host)           host_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Self-checking bench for xadc_drp_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

  localparam int T       = 8;
  localparam int OW      = 2;
  localparam int OVR_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          eoc;
  logic [4:0]    channel;
  logic          host_req;
  logic          host_we;
  logic [6:0]    host_addr;
  logic [15:0]   host_wdata;
  logic          host_ack;
  logic          host_err;
  logic [15:0]   host_rdata;
  logic          den;
  logic          dwe;
  logic [6:0]    daddr;
  logic [15:0]   di;
  logic          drdy;
  logic [15:0]   do_data;
  logic          smp_valid;
  logic [4:0]    smp_chan;
  logic [15:0]   smp_data;
  logic [OW-1:0] ovr_cnt;
  logic          busy;

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(T), .OVR_W(OW)) dut (
    .clk(clk), .reset(reset), .eoc(eoc), .channel(channel),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .den(den), .dwe(dwe), .daddr(daddr), .di(di), .drdy(drdy), .do_data(do_data),
    .smp_valid(smp_valid), .smp_chan(smp_chan), .smp_data(smp_data),
    .ovr_cnt(ovr_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  logic [127:0] dut_vec;
  assign dut_vec = 128'({den, dwe, daddr, di, host_ack, host_err, host_rdata,
                         smp_valid, smp_chan, smp_data, ovr_cnt, busy});

  // ---------------- reference model (transaction level, absolute deadlines)
  int          cyc;
  int          m_kind;   // 0 none, 1 sample readout, 2 host access
  int          m_start;  // cycle of the den edge
  int          m_ovr;
  logic        pend;
  logic [4:0]  pchan;
  logic        m_we;
  logic        e_den, e_dwe, e_ack, e_err, e_sv;
  logic [6:0]  e_daddr;
  logic [15:0] e_di, e_rdata, e_sdat;
  logic [4:0]  e_sch;

  function automatic logic [127:0] model_vec();
    return 128'({e_den, e_dwe, e_daddr, e_di, e_ack, e_err, e_rdata,
                 e_sv, e_sch, e_sdat, OW'(m_ovr), (m_kind != 0)});
  endfunction

  task automatic model_reset();
    m_kind = 0; m_start = 0; m_ovr = 0; pend = 1'b0; pchan = '0; m_we = 1'b0;
    e_den = 0; e_dwe = 0; e_ack = 0; e_err = 0; e_sv = 0;
    e_daddr = '0; e_di = '0; e_rdata = '0; e_sdat = '0; e_sch = '0;
  endtask

  task automatic model_step();
    logic took;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    took = 1'b0;
    e_den = 0; e_dwe = 0; e_ack = 0; e_err = 0; e_sv = 0;
    if (m_kind == 0) begin
      if (pend) begin
        e_den = 1; e_daddr = {2'b00, pchan}; m_kind = 1; m_start = cyc; took = 1'b1;
      end else if (host_req && !eoc) begin
        e_den = 1; e_dwe = host_we; e_daddr = host_addr; e_di = host_wdata;
        m_we = host_we; m_kind = 2; m_start = cyc;
      end
    end else if (drdy) begin
      if (m_kind == 1) begin
        e_sv = 1; e_sch = e_daddr[4:0]; e_sdat = do_data;
      end else begin
        e_ack = 1;
        if (!m_we) e_rdata = do_data;
      end
      m_kind = 0;
    end else if (cyc - m_start == T) begin
      if (m_kind == 2) begin
        e_ack = 1; e_err = 1; e_rdata = '0;
      end
      m_kind = 0;
    end
    if (eoc) begin
      if (pend && !took && m_ovr < OVR_MAX) m_ovr++;
      pend = 1'b1; pchan = channel;
    end else if (took) begin
      pend = 1'b0;
    end
  endtask

  // One clock: model follows the edge, every output is compared 1 ns later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("cycle_model", dut_vec, model_vec());
  endtask

  task automatic set_in(input int e, input int ch, input int rq, input int we,
                        input int ad, input int wd, input int dr, input int dd);
    eoc = 1'(e); channel = 5'(ch); host_req = 1'(rq); host_we = 1'(we);
    host_addr = 7'(ad); host_wdata = 16'(wd); drdy = 1'(dr); do_data = 16'(dd);
  endtask

  // ---------------- vector table
  typedef struct packed {
    logic e; logic [4:0] ch; logic rq; logic we; logic [6:0] ad; logic [15:0] wd;
    logic dr; logic [15:0] dd;
    logic den; logic dwe; logic [6:0] da; logic [15:0] di; logic ak; logic er;
    logic [15:0] rd; logic sv; logic [4:0] sc; logic [15:0] sd; logic bz;
  } vec_t;

  function automatic vec_t mk(input int e, ch, rq, we, ad, wd, dr, dd,
                              input int dn, dw, da, dv, ak, er, rd, sv, sc, sd, bz);
    vec_t v;
    v.e = 1'(e); v.ch = 5'(ch); v.rq = 1'(rq); v.we = 1'(we); v.ad = 7'(ad);
    v.wd = 16'(wd); v.dr = 1'(dr); v.dd = 16'(dd);
    v.den = 1'(dn); v.dwe = 1'(dw); v.da = 7'(da); v.di = 16'(dv); v.ak = 1'(ak);
    v.er = 1'(er); v.rd = 16'(rd); v.sv = 1'(sv); v.sc = 5'(sc); v.sd = 16'(sd); v.bz = 1'(bz);
    return v;
  endfunction

  vec_t vecs[14];
  logic early;
  logic r_eoc, h_req, h_we;
  logic [6:0] h_addr;
  logic [15:0] h_wd;

  initial begin
    // single EOC on VAUX3, then a host read and a host write
    vecs[0]  = mk(1, CH_VAUX3, 0, 0, 0, 0, 0, 0,              0, 0, 0,     0,      0, 0, 0,      0, 0,  0,      0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                     1, 0, 'h13,  0,      0, 0, 0,      0, 0,  0,      1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 'h13,  0,      0, 0, 0,      0, 0,  0,      1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 'h13,  0,      0, 0, 0,      0, 0,  0,      1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 'h13,  0,      0, 0, 0,      0, 0,  0,      1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 'hA5A0,                0, 0, 'h13,  0,      0, 0, 0,      1, 19, 'hA5A0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 'h13,  0,      0, 0, 0,      0, 19, 'hA5A0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 'h48, 0, 0, 0,                  1, 0, 'h48,  0,      0, 0, 0,      0, 19, 'hA5A0, 1);
    vecs[8]  = mk(0, 0, 1, 0, 'h48, 0, 0, 0,                  0, 0, 'h48,  0,      0, 0, 0,      0, 19, 'hA5A0, 1);
    vecs[9]  = mk(0, 0, 1, 0, 'h48, 0, 1, 'h1234,             0, 0, 'h48,  0,      1, 0, 'h1234, 0, 19, 'hA5A0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 'h48,  0,      0, 0, 'h1234, 0, 19, 'hA5A0, 0);
    vecs[11] = mk(0, 0, 1, 1, CFG1, 'h2000, 0, 0,             1, 1, 'h41,  'h2000, 0, 0, 'h1234, 0, 19, 'hA5A0, 1);
    vecs[12] = mk(0, 0, 1, 1, CFG1, 'h2000, 1, 'hBEEF,        0, 0, 'h41,  'h2000, 1, 0, 'h1234, 0, 19, 'hA5A0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 'h41,  'h2000, 0, 0, 'h1234, 0, 19, 'hA5A0, 0);

    cyc = 0;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state", dut_vec, 128'd0);

    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].e, vecs[i].ch, vecs[i].rq, vecs[i].we, vecs[i].ad, vecs[i].wd, vecs[i].dr, vecs[i].dd);
      tick();
      chk($sformatf("vec%0d", i),
          128'({den, dwe, daddr, di, host_ack, host_err, host_rdata, smp_valid, smp_chan, smp_data, busy}),
          128'({vecs[i].den, vecs[i].dwe, vecs[i].da, vecs[i].di, vecs[i].ak, vecs[i].er, vecs[i].rd,
                vecs[i].sv, vecs[i].sc, vecs[i].sd, vecs[i].bz}));
    end

    // collision: EOC ch0 and host read in the same cycle, sample goes first
    set_in(1, CH_TEMP, 1, 0, SEQ_CHSEL0, 0, 0, 0); tick();
    chk("coll_no_host_grant", {den, busy}, 2'b00);
    set_in(0, 0, 1, 0, SEQ_CHSEL0, 0, 0, 0); tick();
    chk("coll_smp_den", {den, dwe, daddr}, {1'b1, 1'b0, 7'h00});
    set_in(0, 0, 1, 0, SEQ_CHSEL0, 0, 1, 'h0111); tick();
    chk("coll_smp_done", {smp_valid, smp_chan, smp_data}, {1'b1, 5'd0, 16'h0111});
    chk("coll_idle_gap", {den, busy}, 2'b00);
    set_in(0, 0, 1, 0, SEQ_CHSEL0, 0, 0, 0); tick();
    chk("coll_host_den", {den, dwe, daddr}, {1'b1, 1'b0, 7'h48});
    set_in(0, 0, 1, 0, SEQ_CHSEL0, 0, 1, 'h0222); tick();
    chk("coll_host_ack", {host_ack, host_err, host_rdata}, {1'b1, 1'b0, 16'h0222});
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // overrun: two EOCs while the host access is in flight
    set_in(0, 0, 1, 0, SEQ_CHSEL1, 0, 0, 0); tick();
    chk("ovr_host_den", {den, daddr}, {1'b1, 7'h49});
    set_in(1, CH_VAUX10, 1, 0, SEQ_CHSEL1, 0, 0, 0); tick();
    set_in(1, CH_VAUX11, 1, 0, SEQ_CHSEL1, 0, 0, 0); tick();
    chk("ovr_cnt_one", ovr_cnt, 1);
    set_in(0, 0, 1, 0, SEQ_CHSEL1, 0, 1, 'h5A5A); tick();
    chk("ovr_host_ack", {host_ack, host_err, host_rdata}, {1'b1, 1'b0, 16'h5A5A});
    set_in(1, 2, 0, 0, 0, 0, 0, 0); tick();   // EOC on the grant cycle
    chk("ovr_smp_daddr", {den, dwe, daddr}, {1'b1, 1'b0, 7'h1B});
    chk("ovr_grant_cycle_no_count", ovr_cnt, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 'h0BB0); tick();
    chk("ovr_smp_done", {smp_valid, smp_chan, smp_data}, {1'b1, 5'd27, 16'h0BB0});
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("regrant_daddr", {den, daddr}, {1'b1, 7'h02});
    set_in(0, 0, 0, 0, 0, 0, 1, 'h0C0C); tick();
    chk("regrant_done", {smp_valid, smp_chan}, {1'b1, 5'd2});
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // timeout on a host read, with EOCs piling up meanwhile
    set_in(0, 0, 1, 0, CFG0, 0, 0, 0); tick();
    chk("tmo_den", {den, daddr}, {1'b1, 7'h40});
    early = 1'b0;
    for (int k = 1; k <= T; k++) begin
      if (k < T) set_in(1, k, 1, 0, CFG0, 0, 0, 0);
      else       set_in(0, 0, 1, 0, CFG0, 0, 0, 0);
      tick();
      if (k < T && host_ack) early = 1'b1;
    end
    chk("tmo_not_early", early, 0);
    chk("tmo_ack", {host_ack, host_err, host_rdata, busy}, {1'b1, 1'b1, 16'h0, 1'b0});
    chk("ovr_saturated", ovr_cnt, OVR_MAX);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("tmo_then_smp_den", {den, daddr}, {1'b1, 7'h07});
    set_in(0, 0, 0, 0, 0, 0, 1, 'hCAFE); tick();
    chk("tmo_then_smp_done", {smp_valid, smp_chan, smp_data}, {1'b1, 5'd7, 16'hCAFE});
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // reset in the middle of a host write, then a stray drdy
    set_in(0, 0, 1, 1, SEQ_CHSEL0, 'h00FF, 0, 0); tick();
    tick();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_zero", dut_vec, 128'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1, 'hDEAD); tick();
    chk("rst_stray_drdy", {host_ack, smp_valid, busy, den}, 4'b0000);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_quiet", dut_vec, 128'd0);

    // randomized traffic checked cycle by cycle against the model
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      r_eoc = ($urandom_range(0, 39) == 0);
      if (h_req) begin
        if (e_ack) h_req = 1'b0;
        else if (m_kind == 0 && $urandom_range(0, 19) == 0) h_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        h_req = 1'b1; h_we = 1'($urandom); h_addr = 7'($urandom); h_wd = 16'($urandom);
      end
      set_in(r_eoc, int'($urandom_range(0, 31)), h_req, h_we, h_addr, h_wd,
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, 65535)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
